// File: rtl/combined_wire.sv
// Inter-stage record types shared by writeback, csr_file and the fetch redirect path.
package combined_wire;
    localparam int XLEN = 64;

    typedef struct packed {
        logic            csr_write_enable;
        logic [11:0]     csr_dest_addr;
        logic [XLEN-1:0] csr_write_data;
        logic            is_ecall;
        logic            is_ebreak;
        logic            is_mret;
        logic [XLEN-1:0] pc;
    } csr_writer;

    typedef struct packed {
        logic            do_jump;
        logic [XLEN-1:0] dest_addr;
        logic [31:0]     jump_inst;
        logic [XLEN-1:0] inst_counter;
    } jump_writer;
endpackage

// File: rtl/csr_pkg.sv
// CSR addresses, mstatus bit layout and the commit sequencer state encoding.
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_LO   = 11;
    localparam int MPP_HI   = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAIN,
        S_T_EPC,
        S_T_CAUSE,
        S_T_STAT,
        S_T_JMP,
        S_MR_STAT,
        S_MR_JMP
    } csr_seq_state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_PLAIN,
        CLS_TRAP,
        CLS_MRET
    } csr_class_t;

    // Traps win over mret, mret wins over a plain write.
    function automatic csr_class_t classify(
        input logic ecall,
        input logic ebreak,
        input logic mret,
        input logic we
    );
        csr_class_t c;
        if (ecall || ebreak) c = CLS_TRAP;
        else if (mret)       c = CLS_MRET;
        else if (we)         c = CLS_PLAIN;
        else                 c = CLS_NONE;
        return c;
    endfunction
endpackage

// File: rtl/csr_commit_ctrl_if.sv
// Writeback-side handshake, csr_file read/write port and redirect bundle.
interface csr_commit_ctrl_if;
    import combined_wire::*;

    logic            in_valid;
    logic            in_ready;
    csr_writer       in_csr;
    logic [XLEN-1:0] mstatus_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic            csr_we;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic            busy;
    jump_writer      redirect;

    modport master (
        output in_valid, in_csr, mstatus_q, mtvec_q, mepc_q,
        input  in_ready, csr_we, csr_waddr, csr_wdata, busy, redirect
    );

    modport slave (
        input  in_valid, in_csr, mstatus_q, mtvec_q, mepc_q,
        output in_ready, csr_we, csr_waddr, csr_wdata, busy, redirect
    );
endinterface

// File: rtl/csr_commit_ctrl_mstatus_xform.sv
// mstatus rewrite for trap entry (is_trap=1) and mret return (is_trap=0).
module mstatus_xform
    import csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] mstatus_in,
    input  logic            is_trap,
    output logic [XLEN-1:0] mstatus_out
);
    always_comb begin
        mstatus_out = mstatus_in;
        if (is_trap) begin
            mstatus_out[MPIE_BIT]      = mstatus_in[MIE_BIT];
            mstatus_out[MIE_BIT]       = 1'b0;
            mstatus_out[MPP_HI:MPP_LO] = 2'b11;
        end else begin
            mstatus_out[MIE_BIT]       = mstatus_in[MPIE_BIT];
            mstatus_out[MPIE_BIT]      = 1'b1;
            mstatus_out[MPP_HI:MPP_LO] = 2'b00;
        end
    end
endmodule

// File: rtl/csr_commit_ctrl.sv
// Serialises committed CSR records (plain, ecall/ebreak, mret) onto the
// single csr_file write port and issues the trap/return redirect.
module csr_commit_ctrl
    import combined_wire::*;
    import csr_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int CAUSE_ECALL  = 11,
    parameter int CAUSE_EBREAK = 3
) (
    input logic               clk,
    input logic               reset,
    csr_commit_ctrl_if.slave  bus
);
    csr_seq_state_t  state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] wdat_q, wdat_d;
    logic [XLEN-1:0] mst_q, mst_d;
    logic [11:0]     addr_q, addr_d;
    logic            ebrk_q, ebrk_d;

    csr_class_t      cls;
    logic            idle;
    logic            accept;
    logic [XLEN-1:0] mst_new;
    logic [XLEN-1:0] cause;

    assign cls = classify(bus.in_csr.is_ecall, bus.in_csr.is_ebreak,
                          bus.in_csr.is_mret, bus.in_csr.csr_write_enable);
    assign idle   = (state_q == S_IDLE);
    assign accept = bus.in_valid & idle;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            wdat_q  <= '0;
            mst_q   <= '0;
            addr_q  <= '0;
            ebrk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wdat_q  <= wdat_d;
            mst_q   <= mst_d;
            addr_q  <= addr_d;
            ebrk_q  <= ebrk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wdat_d  = wdat_q;
        mst_d   = mst_q;
        addr_d  = addr_q;
        ebrk_d  = ebrk_q;
        if (accept) begin
            pc_d   = bus.in_csr.pc;
            wdat_d = bus.in_csr.csr_write_data;
            addr_d = bus.in_csr.csr_dest_addr;
            mst_d  = bus.mstatus_q;
            ebrk_d = ~bus.in_csr.is_ecall;
        end
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (cls)
                        CLS_TRAP:  state_d = S_T_EPC;
                        CLS_MRET:  state_d = S_MR_STAT;
                        CLS_PLAIN: state_d = S_PLAIN;
                        default:   state_d = S_IDLE;
                    endcase
                end
            end
            S_PLAIN:   state_d = S_IDLE;
            S_T_EPC:   state_d = S_T_CAUSE;
            S_T_CAUSE: state_d = S_T_STAT;
            S_T_STAT:  state_d = S_T_JMP;
            S_T_JMP:   state_d = S_IDLE;
            S_MR_STAT: state_d = S_MR_JMP;
            S_MR_JMP:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    mstatus_xform #(.XLEN(XLEN)) u_xform (
        .mstatus_in  (mst_q),
        .is_trap     (state_q == S_T_STAT),
        .mstatus_out (mst_new)
    );

    assign cause = ebrk_q ? XLEN'(CAUSE_EBREAK) : XLEN'(CAUSE_ECALL);

    // Outputs depend on registered state; jump targets read the live CSRs.
    always_comb begin
        bus.csr_we    = 1'b0;
        bus.csr_waddr = '0;
        bus.csr_wdata = '0;
        bus.redirect  = '0;
        unique case (state_q)
            S_PLAIN: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = addr_q;
                bus.csr_wdata = wdat_q;
            end
            S_T_EPC: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = CSR_MEPC;
                bus.csr_wdata = pc_q;
            end
            S_T_CAUSE: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = CSR_MCAUSE;
                bus.csr_wdata = cause;
            end
            S_T_STAT, S_MR_STAT: begin
                bus.csr_we    = 1'b1;
                bus.csr_waddr = CSR_MSTATUS;
                bus.csr_wdata = mst_new;
            end
            S_T_JMP: begin
                bus.redirect.do_jump   = 1'b1;
                bus.redirect.dest_addr = {bus.mtvec_q[XLEN-1:2], 2'b00};
            end
            S_MR_JMP: begin
                bus.redirect.do_jump   = 1'b1;
                bus.redirect.dest_addr = {bus.mepc_q[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
    end

    assign bus.in_ready = idle;
    assign bus.busy     = ~idle | (bus.in_valid &
                          ((cls == CLS_TRAP) | (cls == CLS_MRET)));
endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Directed and randomized checks of csr_commit_ctrl against a queue-based model.
module tb_csr_commit_ctrl;
    import combined_wire::*;
    import csr_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    csr_commit_ctrl_if bus();

    csr_commit_ctrl #(
        .XLEN(64), .CAUSE_ECALL(11), .CAUSE_EBREAK(3)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [63:0] data;
        logic        jmp;
        logic        use_mepc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    csr_writer r;

    function automatic logic [63:0] trap_ms(logic [63:0] m);
        return (m & ~64'h1888) | (((m >> 3) & 64'h1) << 7) | 64'h1800;
    endfunction

    function automatic logic [63:0] mret_ms(logic [63:0] m);
        return (m & ~64'h1888) | (((m >> 7) & 64'h1) << 3) | 64'h80;
    endfunction

    function automatic exp_t wr(logic [11:0] a, logic [63:0] d);
        exp_t x;
        x.we = 1'b1; x.addr = a; x.data = d; x.jmp = 1'b0; x.use_mepc = 1'b0;
        return x;
    endfunction

    function automatic exp_t jp(logic m);
        exp_t x;
        x.we = 1'b0; x.addr = '0; x.data = '0; x.jmp = 1'b1; x.use_mepc = m;
        return x;
    endfunction

    // Model: one queued action per cycle; new requests only when queue empty.
    always @(posedge clk) begin
        if (reset) begin
            if (q.size() != 0) begin
                void'(q.pop_front());
            end else if (bus.in_valid) begin
                r = bus.in_csr;
                if (r.is_ecall || r.is_ebreak) begin
                    q.push_back(wr(12'h341, r.pc));
                    q.push_back(wr(12'h342, r.is_ecall ? 64'd11 : 64'd3));
                    q.push_back(wr(12'h300, trap_ms(bus.mstatus_q)));
                    q.push_back(jp(1'b0));
                end else if (r.is_mret) begin
                    q.push_back(wr(12'h300, mret_ms(bus.mstatus_q)));
                    q.push_back(jp(1'b1));
                end else if (r.csr_write_enable) begin
                    q.push_back(wr(r.csr_dest_addr, r.csr_write_data));
                end
            end
        end
    end

    always @(negedge reset) q.delete();

    logic        x_busy, x_rdy;
    logic [63:0] x_dest;

    always @(negedge clk) begin
        if (q.size() != 0) e = q[0];
        else begin
            e.we = 0; e.addr = 0; e.data = 0; e.jmp = 0; e.use_mepc = 0;
        end
        x_rdy  = (q.size() == 0);
        x_busy = (q.size() != 0) || (bus.in_valid &&
                 (bus.in_csr.is_ecall || bus.in_csr.is_ebreak || bus.in_csr.is_mret));
        x_dest = !e.jmp ? 64'h0 :
                 e.use_mepc ? (bus.mepc_q & ~64'h1) : (bus.mtvec_q & ~64'h3);
        total++;
        if (bus.csr_we !== e.we || bus.csr_waddr !== e.addr ||
            bus.csr_wdata !== e.data || bus.redirect.do_jump !== e.jmp ||
            bus.redirect.dest_addr !== x_dest || bus.redirect.jump_inst !== 32'h0 ||
            bus.redirect.inst_counter !== 64'h0 || bus.busy !== x_busy ||
            bus.in_ready !== x_rdy) begin
            bad++;
            $display("FAIL cycle t=%0t act we=%b a=%h d=%h j=%b dst=%h bsy=%b rdy=%b req we=%b a=%h d=%h j=%b dst=%h bsy=%b rdy=%b",
                     $time, bus.csr_we, bus.csr_waddr, bus.csr_wdata,
                     bus.redirect.do_jump, bus.redirect.dest_addr, bus.busy,
                     bus.in_ready, e.we, e.addr, e.data, e.jmp, x_dest,
                     x_busy, x_rdy);
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic csr_writer mk(logic ec, logic eb, logic mr, logic we,
                                     logic [11:0] a, logic [63:0] d,
                                     logic [63:0] pc);
        csr_writer x;
        x.is_ecall = ec; x.is_ebreak = eb; x.is_mret = mr;
        x.csr_write_enable = we; x.csr_dest_addr = a;
        x.csr_write_data = d; x.pc = pc;
        return x;
    endfunction

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_csr    = '0;
        bus.mstatus_q = '0;
        bus.mtvec_q   = '0;
        bus.mepc_q    = '0;
        step();
        chk("rst_we", {63'd0, bus.csr_we}, 64'd0);
        chk("rst_rdy", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_bsy", {63'd0, bus.busy}, 64'd0);
        chk("rst_jmp", {63'd0, bus.redirect.do_jump}, 64'd0);
        #2 reset = 1'b1;
        step();

        // ecall
        bus.mstatus_q = 64'h8;
        bus.mtvec_q   = 64'h8000_0003;
        bus.in_csr    = mk(1, 0, 0, 0, 12'h0, 64'h0, 64'h8000_0100);
        bus.in_valid  = 1'b1;
        #1 chk("ec_bsy0", {63'd0, bus.busy}, 64'd1);
        step();
        bus.in_valid = 1'b0;
        chk("ec_epc_a", {52'd0, bus.csr_waddr}, 64'h341);
        chk("ec_epc_d", bus.csr_wdata, 64'h8000_0100);
        step();
        chk("ec_cause_a", {52'd0, bus.csr_waddr}, 64'h342);
        chk("ec_cause_d", bus.csr_wdata, 64'd11);
        step();
        chk("ec_stat_a", {52'd0, bus.csr_waddr}, 64'h300);
        chk("ec_stat_d", bus.csr_wdata, 64'h1880);
        step();
        chk("ec_jmp", {63'd0, bus.redirect.do_jump}, 64'd1);
        chk("ec_dest", bus.redirect.dest_addr, 64'h8000_0000);
        chk("ec_jmp_we", {63'd0, bus.csr_we}, 64'd0);
        step();
        chk("ec_end_bsy", {63'd0, bus.busy}, 64'd0);

        // back-to-back plain writes
        bus.in_csr   = mk(0, 0, 0, 1, 12'h340, 64'hDEAD_BEEF, 64'h0);
        bus.in_valid = 1'b1;
        step();
        bus.in_csr = mk(0, 0, 0, 1, 12'h305, 64'h1234_5678, 64'h0);
        chk("pl1_we", {63'd0, bus.csr_we}, 64'd1);
        chk("pl1_a", {52'd0, bus.csr_waddr}, 64'h340);
        chk("pl1_d", bus.csr_wdata, 64'hDEAD_BEEF);
        chk("pl1_rdy", {63'd0, bus.in_ready}, 64'd0);
        step();
        chk("pl_gap_we", {63'd0, bus.csr_we}, 64'd0);
        step();
        bus.in_valid = 1'b0;
        chk("pl2_a", {52'd0, bus.csr_waddr}, 64'h305);
        chk("pl2_d", bus.csr_wdata, 64'h1234_5678);
        step();

        // ebreak with a stray write enable
        bus.mstatus_q = 64'h0;
        bus.in_csr    = mk(0, 1, 0, 1, 12'h340, 64'h55, 64'h8000_0200);
        bus.in_valid  = 1'b1;
        #1 chk("eb_bsy0", {63'd0, bus.busy}, 64'd1);
        step();
        bus.in_valid = 1'b0;
        chk("eb_a1", {52'd0, bus.csr_waddr}, 64'h341);
        chk("eb_bsy1", {63'd0, bus.busy}, 64'd1);
        step();
        chk("eb_cause", bus.csr_wdata, 64'd3);
        chk("eb_bsy2", {63'd0, bus.busy}, 64'd1);
        step();
        chk("eb_stat", bus.csr_wdata, 64'h1800);
        chk("eb_bsy3", {63'd0, bus.busy}, 64'd1);
        step();
        chk("eb_jmp", {63'd0, bus.redirect.do_jump}, 64'd1);
        chk("eb_bsy4", {63'd0, bus.busy}, 64'd1);
        step();
        chk("eb_end_bsy", {63'd0, bus.busy}, 64'd0);
        chk("eb_end_we", {63'd0, bus.csr_we}, 64'd0);

        // mret
        bus.mstatus_q = 64'h1880;
        bus.mepc_q    = 64'h8000_0105;
        bus.in_csr    = mk(0, 0, 1, 0, 12'h0, 64'h0, 64'h0);
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("mr_a", {52'd0, bus.csr_waddr}, 64'h300);
        chk("mr_d", bus.csr_wdata, 64'h88);
        step();
        chk("mr_jmp", {63'd0, bus.redirect.do_jump}, 64'd1);
        chk("mr_dest", bus.redirect.dest_addr, 64'h8000_0104);
        step();
        chk("mr_end_jmp", {63'd0, bus.redirect.do_jump}, 64'd0);

        // reset in the middle of an ecall sequence
        bus.mstatus_q = 64'h8;
        bus.in_csr    = mk(1, 0, 0, 0, 12'h0, 64'h0, 64'h8000_0300);
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("ab_cause", {52'd0, bus.csr_waddr}, 64'h342);
        #2 reset = 1'b0;
        #1;
        chk("ab_we", {63'd0, bus.csr_we}, 64'd0);
        chk("ab_bsy", {63'd0, bus.busy}, 64'd0);
        chk("ab_rdy", {63'd0, bus.in_ready}, 64'd1);
        step();
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ab_no_wr", {63'd0, bus.csr_we}, 64'd0);
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step();
            bus.in_valid  = ($urandom_range(0, 9) < 6);
            bus.in_csr    = mk(($urandom_range(0, 7) == 0),
                               ($urandom_range(0, 7) == 0),
                               ($urandom_range(0, 5) == 0),
                               ($urandom_range(0, 3) != 0),
                               12'($urandom), {$urandom, $urandom},
                               {$urandom, $urandom});
            bus.mstatus_q = {$urandom, $urandom};
            bus.mtvec_q   = {$urandom, $urandom};
            bus.mepc_q    = {$urandom, $urandom};
            if (i == 300) begin
                #2 reset = 1'b0;
                #4 reset = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        repeat (6) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
